// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver: parity modes, FSM encodings
// and the parity helper used by both the transmitter and the receiver.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // Narrower words are zero-extended by the caller; zeros do not alter the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic [1:0] mode);
        logic p;
        p = ^data;
        case (mode)
            PARITY_EVEN: parity_bit = p;
            PARITY_ODD:  parity_bit = ~p;
            default:     parity_bit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_if.sv
// Host-side bus of the UART: TX valid/ready, RX FIFO head/pop and sticky errors.
interface uart_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [COUNT_W-1:0]   rx_count;
    logic                 err_parity;
    logic                 err_frame;
    logic                 err_overrun;
    logic                 err_clr;

    modport master (
        output tx_data, tx_valid, rx_ready, err_clr,
        input  tx_ready, rx_data, rx_valid, rx_count,
        input  err_parity, err_frame, err_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready, err_clr,
        output tx_ready, rx_data, rx_valid, rx_count,
        output err_parity, err_frame, err_overrun
    );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO for received words; a pop on a full FIFO makes room for a
// same-cycle push, and the head holds the last popped word while empty.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] last_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (count_r == {CNT_W{1'b0}});
    assign full  = (count_r == CNT_W'(DEPTH));
    assign count = count_r;
    assign head  = empty ? last_r : mem_r[rd_ptr_r];

    // Qualify push/pop against the occupancy seen this cycle.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer, occupancy and last-popped-word registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            last_r   <= {WIDTH{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                last_r   <= mem_r[rd_ptr_r];
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: divisor-timed TX shifter with valid/ready, mid-bit
// sampling RX with start validation, RX FIFO and sticky error flags.
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic clk,
    input  logic reset_n,
    uart_if.slave bus,
    output logic tx_pin,
    input  logic rx_pin
);
    localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             PAR_EN    = (PARITY != 0);
    localparam logic [1:0]       PAR_MODE  = 2'(PARITY);

    tx_state_e            tx_state_r, tx_state_s;
    logic [CNT_W-1:0]     tx_cnt_r, tx_cnt_s;
    logic [BIT_W-1:0]     tx_bit_r, tx_bit_s;
    logic [DATA_BITS-1:0] tx_shift_r, tx_shift_s;
    logic                 tx_par_r, tx_par_s;
    logic                 tx_pin_r, tx_pin_s;
    logic                 tx_ready_r;

    rx_state_e            rx_state_r, rx_state_s;
    logic [CNT_W-1:0]     rx_cnt_r, rx_cnt_s;
    logic [BIT_W-1:0]     rx_bit_r, rx_bit_s;
    logic [DATA_BITS-1:0] rx_shift_r, rx_shift_s;
    logic                 rx_par_r, rx_par_s;
    logic                 rx_s1_r, rx_s2_r, rx_prev_r;
    logic                 push_s, par_err_s, frame_err_s, ovr_err_s, pop_s;
    logic                 fifo_full_s, fifo_empty_s;
    logic                 err_parity_r, err_frame_r, err_overrun_r;

    assign tx_pin          = tx_pin_r;
    assign bus.tx_ready    = tx_ready_r;
    assign bus.rx_valid    = ~fifo_empty_s;
    assign bus.err_parity  = err_parity_r;
    assign bus.err_frame   = err_frame_r;
    assign bus.err_overrun = err_overrun_r;

    // TX state register; pin and ready are registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= {CNT_W{1'b0}};
            tx_bit_r   <= {BIT_W{1'b0}};
            tx_shift_r <= {DATA_BITS{1'b0}};
            tx_par_r   <= 1'b0;
            tx_pin_r   <= 1'b1;
            tx_ready_r <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_par_r   <= tx_par_s;
            tx_pin_r   <= tx_pin_s;
            tx_ready_r <= (tx_state_s == TX_IDLE);
        end
    end

    // TX next state: each bit period is CLKS_PER_BIT cycles, stop is STOP_BITS periods.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r + CNT_W'(1);
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_par_s   = tx_par_r;
        case (tx_state_r)
            TX_IDLE: begin
                tx_cnt_s = {CNT_W{1'b0}};
                if (bus.tx_valid) begin
                    tx_state_s = TX_START;
                    tx_shift_s = bus.tx_data;
                    tx_par_s   = parity_bit(MAX_DATA_BITS'(bus.tx_data), PAR_MODE);
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_state_s = TX_DATA;
                    tx_cnt_s   = {CNT_W{1'b0}};
                    tx_bit_s   = {BIT_W{1'b0}};
                end else begin
                    tx_state_s = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s   = {CNT_W{1'b0}};
                    tx_shift_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
                    if (tx_bit_r == DATA_LAST) begin
                        tx_state_s = PAR_EN ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bit_s = tx_bit_r + BIT_W'(1);
                    end
                end else begin
                    tx_state_s = TX_DATA;
                end
            end
            TX_PARITY: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_state_s = TX_STOP;
                    tx_cnt_s   = {CNT_W{1'b0}};
                end else begin
                    tx_state_s = TX_PARITY;
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == STOP_LAST) begin
                    tx_state_s = TX_IDLE;
                    tx_cnt_s   = {CNT_W{1'b0}};
                end else begin
                    tx_state_s = TX_STOP;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
                tx_cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // TX output: line level for the state being entered.
    always_comb begin
        tx_pin_s = 1'b1;
        case (tx_state_s)
            TX_START:  tx_pin_s = 1'b0;
            TX_DATA:   tx_pin_s = tx_shift_s[0];
            TX_PARITY: tx_pin_s = tx_par_s;
            default:   tx_pin_s = 1'b1;
        endcase
    end

    // RX synchroniser, edge-detect history and state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_r    <= 1'b1;
            rx_s2_r    <= 1'b1;
            rx_prev_r  <= 1'b1;
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= {CNT_W{1'b0}};
            rx_bit_r   <= {BIT_W{1'b0}};
            rx_shift_r <= {DATA_BITS{1'b0}};
            rx_par_r   <= 1'b0;
        end else begin
            rx_s1_r    <= rx_pin;
            rx_s2_r    <= rx_s1_r;
            rx_prev_r  <= rx_s2_r;
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
            rx_par_r   <= rx_par_s;
        end
    end

    // RX next state: half a bit to the start midpoint, then one bit per sample.
    always_comb begin
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_cnt_r + CNT_W'(1);
        rx_bit_s   = rx_bit_r;
        rx_shift_s = rx_shift_r;
        rx_par_s   = rx_par_r;
        case (rx_state_r)
            RX_IDLE: begin
                rx_cnt_s = {CNT_W{1'b0}};
                if (rx_prev_r && !rx_s2_r) begin
                    rx_state_s = RX_START;
                end else begin
                    rx_state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_s   = {CNT_W{1'b0}};
                    rx_bit_s   = {BIT_W{1'b0}};
                    rx_state_s = rx_s2_r ? RX_IDLE : RX_DATA;
                end else begin
                    rx_state_s = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s   = {CNT_W{1'b0}};
                    rx_shift_s = {rx_s2_r, rx_shift_r[DATA_BITS-1:1]};
                    if (rx_bit_r == DATA_LAST) begin
                        rx_state_s = PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_s = rx_bit_r + BIT_W'(1);
                    end
                end else begin
                    rx_state_s = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_state_s = RX_STOP;
                    rx_cnt_s   = {CNT_W{1'b0}};
                    rx_par_s   = rx_s2_r;
                end else begin
                    rx_state_s = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_state_s = RX_IDLE;
                    rx_cnt_s   = {CNT_W{1'b0}};
                end else begin
                    rx_state_s = RX_STOP;
                end
            end
            default: begin
                rx_state_s = RX_IDLE;
                rx_cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // RX output: push and error detection at the first stop-bit sample.
    always_comb begin
        push_s = 1'b0;
        case (rx_state_r)
            RX_STOP: push_s = (rx_cnt_r == BIT_LAST);
            default: push_s = 1'b0;
        endcase
        pop_s       = bus.rx_ready & ~fifo_empty_s;
        par_err_s   = push_s & PAR_EN &
                      (rx_par_r != parity_bit(MAX_DATA_BITS'(rx_shift_r), PAR_MODE));
        frame_err_s = push_s & ~rx_s2_r;
        ovr_err_s   = push_s & fifo_full_s & ~pop_s;
    end

    // Sticky error flags; a same-cycle set wins over err_clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_parity_r  <= 1'b0;
            err_frame_r   <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            err_parity_r  <= par_err_s   | (err_parity_r  & ~bus.err_clr);
            err_frame_r   <= frame_err_s | (err_frame_r   & ~bus.err_clr);
            err_overrun_r <= ovr_err_s   | (err_overrun_r & ~bus.err_clr);
        end
    end

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (rx_shift_r),
        .pop       (bus.rx_ready),
        .head      (bus.rx_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (bus.rx_count)
    );

endmodule
